// File: rtl/object_compositor.sv
// object_compositor: three-stage pixel compositor for the ball, obstacles, borders and background.
// It also accumulates ball/obstacle overlap per frame and publishes the flags when the frame closes.
module object_compositor #(
    parameter int NUM_OBS  = 4,
    parameter int COORD_W  = 10,
    parameter int FINISH_X = 580,
    parameter int BORDER_L = 50,
    parameter int BORDER_R = 590
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic [COORD_W-1:0]         DrawX,
    input  logic [COORD_W-1:0]         DrawY,
    input  logic                       vde,
    input  logic                       frame_start,
    input  logic [COORD_W-1:0]         BallX,
    input  logic [COORD_W-1:0]         BallY,
    input  logic [COORD_W-1:0]         Ball_size,
    input  logic [NUM_OBS*COORD_W-1:0] ObsX,
    input  logic [NUM_OBS*COORD_W-1:0] ObsY,
    input  logic [COORD_W-1:0]         Obs_size,
    input  logic [NUM_OBS-1:0]         obs_enable,
    input  logic [3:0]                 background,
    input  logic [1:0]                 current_level,
    output logic [3:0]                 Red,
    output logic [3:0]                 Green,
    output logic [3:0]                 Blue,
    output logic [NUM_OBS-1:0]         collision_flags,
    output logic                       collision_any,
    output logic                       collision_pulse,
    output logic                       finish_line_reached
);
    localparam int DW   = COORD_W + 1;
    localparam int SQ_W = 2*COORD_W + 2;

    function automatic logic signed [DW-1:0] diff(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    function automatic logic [SQ_W-1:0] sq(input logic signed [DW-1:0] d);
        logic [DW-1:0] m;
        m = d[DW-1] ? DW'(-d) : DW'(d);
        return SQ_W'(m) * SQ_W'(m);
    endfunction

    logic                  v1, brd1, v2, brd2, ball_on;
    logic signed [DW-1:0]  bdx, bdy;
    logic signed [DW-1:0]  odx [NUM_OBS];
    logic signed [DW-1:0]  ody [NUM_OBS];
    logic [SQ_W-1:0]       br2, or2;
    logic [NUM_OBS-1:0]    en1, obs_on, obs_on_d, hit, s2_hit, pending;
    logic [11:0]           pal, rgb_d;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            v1   <= 1'b0;
            brd1 <= 1'b0;
            bdx  <= '0;
            bdy  <= '0;
            br2  <= '0;
            or2  <= '0;
            en1  <= '0;
            for (int i = 0; i < NUM_OBS; i++) begin
                odx[i] <= '0;
                ody[i] <= '0;
            end
        end else begin
            v1   <= vde;
            brd1 <= (DrawX <= COORD_W'(BORDER_L)) || (DrawX >= COORD_W'(BORDER_R));
            bdx  <= diff(DrawX, BallX);
            bdy  <= diff(DrawY, BallY);
            br2  <= sq($signed({1'b0, Ball_size}));
            or2  <= sq($signed({1'b0, Obs_size}));
            en1  <= obs_enable;
            for (int i = 0; i < NUM_OBS; i++) begin
                odx[i] <= diff(DrawX, ObsX[i*COORD_W +: COORD_W]);
                ody[i] <= diff(DrawY, ObsY[i*COORD_W +: COORD_W]);
            end
        end
    end

    always_comb begin
        obs_on_d = '0;
        for (int i = 0; i < NUM_OBS; i++)
            obs_on_d[i] = (sq(odx[i]) + sq(ody[i]) <= or2) & en1[i];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            v2      <= 1'b0;
            brd2    <= 1'b0;
            ball_on <= 1'b0;
            obs_on  <= '0;
        end else begin
            v2      <= v1;
            brd2    <= brd1;
            ball_on <= (sq(bdx) + sq(bdy) <= br2);
            obs_on  <= obs_on_d;
        end
    end

    always_comb begin
        pal   = current_level == 2'd0 ? 12'hF00 :
                current_level == 2'd1 ? 12'hF80 :
                current_level == 2'd2 ? 12'hF0F : 12'h00F;
        rgb_d = !v2      ? 12'h000 :
                ball_on  ? 12'h0F0 :
                |obs_on  ? pal     :
                brd2     ? 12'h061 : {3{background}};
    end

    // Hits still in S2 on the closing cycle belong to the frame being closed.
    assign s2_hit  = {NUM_OBS{v2 & ball_on}} & obs_on;
    assign pending = hit | s2_hit;
    assign collision_any = |collision_flags;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            {Red, Green, Blue}  <= '0;
            hit                 <= '0;
            collision_flags     <= '0;
            collision_pulse     <= 1'b0;
            finish_line_reached <= 1'b0;
        end else begin
            {Red, Green, Blue} <= rgb_d;
            hit                <= frame_start ? '0 : pending;
            collision_pulse    <= frame_start & |pending;
            if (frame_start) begin
                collision_flags     <= pending;
                finish_line_reached <= BallX >= COORD_W'(FINISH_X);
            end
        end
    end
endmodule

// File: tb/tb_object_compositor.sv
// tb_object_compositor: scoreboard bench for colour latency/priority and per-frame collision flags.
module tb_object_compositor;
    localparam int N = 4;
    localparam int W = 10;

    logic           Clk = 1'b0;
    logic           Reset_n = 1'b0;
    logic [W-1:0]   DrawX = '0, DrawY = '0;
    logic           vde = 1'b0, frame_start = 1'b0;
    logic [W-1:0]   BallX = '0, BallY = '0, Ball_size = '0;
    logic [N*W-1:0] ObsX = '0, ObsY = '0;
    logic [W-1:0]   Obs_size = '0;
    logic [N-1:0]   obs_enable = '0;
    logic [3:0]     background = '0;
    logic [1:0]     current_level = '0;
    logic [3:0]     Red, Green, Blue;
    logic [N-1:0]   collision_flags;
    logic           collision_any, collision_pulse, finish_line_reached;

    int errors = 0;
    int checks = 0;
    logic [11:0] sb [$];

    object_compositor dut (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .vde(vde),
        .frame_start(frame_start), .BallX(BallX), .BallY(BallY), .Ball_size(Ball_size),
        .ObsX(ObsX), .ObsY(ObsY), .Obs_size(Obs_size), .obs_enable(obs_enable),
        .background(background), .current_level(current_level),
        .Red(Red), .Green(Green), .Blue(Blue), .collision_flags(collision_flags),
        .collision_any(collision_any), .collision_pulse(collision_pulse),
        .finish_line_reached(finish_line_reached)
    );

    always #5 Clk = ~Clk;

    function automatic logic [11:0] model(input int x, input int y, input logic v);
        int  dx, dy, r;
        logic obs;
        obs = 1'b0;
        if (!v) return 12'h000;
        dx = x - int'(BallX);
        dy = y - int'(BallY);
        r  = int'(Ball_size);
        if (dx*dx + dy*dy <= r*r) return 12'h0F0;
        for (int i = 0; i < N; i++) begin
            dx = x - int'(ObsX[i*W +: W]);
            dy = y - int'(ObsY[i*W +: W]);
            r  = int'(Obs_size);
            if (obs_enable[i] && dx*dx + dy*dy <= r*r) obs = 1'b1;
        end
        if (obs) case (current_level)
            2'd0: return 12'hF00;
            2'd1: return 12'hF80;
            2'd2: return 12'hF0F;
            default: return 12'h00F;
        endcase
        if (x <= 50 || x >= 590) return 12'h061;
        return {3{background}};
    endfunction

    task automatic pix(input int x, input int y, input logic v, input logic fs);
        logic [11:0] e;
        DrawX = W'(x);
        DrawY = W'(y);
        vde = v;
        frame_start = fs;
        sb.push_back(model(x, y, v));
        @(posedge Clk);
        #1;
        frame_start = 1'b0;
        if (sb.size() >= 3) begin
            e = sb.pop_front();
            checks++;
            if ({Red, Green, Blue} !== e) begin
                errors++;
                $display("FAIL rgb pixel: got %h want %h at %0t", {Red, Green, Blue}, e, $time);
            end
        end
    endtask

    task automatic flush();
        repeat (3) pix(0, 0, 1'b0, 1'b0);
    endtask

    task automatic set_obs(input int i, input int x, input int y);
        ObsX[i*W +: W] = W'(x);
        ObsY[i*W +: W] = W'(y);
    endtask

    task automatic close_frame(input string name, input logic [N-1:0] ef, input logic ep);
        pix(0, 0, 1'b0, 1'b1);
        checks++;
        if (collision_flags !== ef || collision_any !== |ef || collision_pulse !== ep) begin
            errors++;
            $display("FAIL %s: flags=%b any=%b pulse=%b want flags=%b any=%b pulse=%b",
                     name, collision_flags, collision_any, collision_pulse, ef, |ef, ep);
        end
    endtask

    task automatic scan();
        for (int y = 236; y <= 244; y++)
            for (int x = 314; x <= 330; x++)
                pix(x, y, 1'b1, 1'b0);
        flush();
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({Red, Green, Blue, collision_flags, collision_any, collision_pulse, finish_line_reached} !== '0) begin
            errors++;
            $display("FAIL %s: rgb=%h flags=%b any=%b pulse=%b finish=%b want all 0",
                     name, {Red, Green, Blue}, collision_flags, collision_any, collision_pulse, finish_line_reached);
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        DrawX = 10'd321; DrawY = 10'd240; vde = 1'b1; frame_start = 1'b1;
        BallX = 10'd320; BallY = 10'd240; Ball_size = 10'd4; Obs_size = 10'd4;
        obs_enable = '1; background = 4'd7; current_level = 2'd2;
        set_obs(0, 320, 240);
        repeat (5) @(posedge Clk);
        #1;
        check_zero("reset_state");
        frame_start = 1'b0;
        for (int i = 0; i < N; i++) set_obs(i, 100 + 50*i, 400);
        sb.delete();
        Reset_n = 1'b1;
        pix(100, 100, 1'b1, 1'b0);
        flush();
    endtask

    task automatic test_priority();
        set_obs(0, 322, 240);
        pix(320, 240, 1'b1, 1'b0);
        pix(325, 240, 1'b1, 1'b0);
        pix(40, 10, 1'b1, 1'b0);
        flush();
        set_obs(0, 100, 400);
        close_frame("priority_obs0_hit", 4'b0001, 1'b1);
    endtask

    task automatic test_collision();
        set_obs(2, 324, 240);
        scan();
        close_frame("obs2_collision", 4'b0100, 1'b1);
        pix(0, 0, 1'b0, 1'b0);
        checks++;
        if (collision_pulse !== 1'b0 || collision_flags !== 4'b0100) begin
            errors++;
            $display("FAIL pulse_hold: pulse=%b flags=%b want pulse=0 flags=0100", collision_pulse, collision_flags);
        end
        set_obs(2, 200, 400);
        scan();
        close_frame("no_overlap_frame", 4'b0000, 1'b0);
    endtask

    task automatic test_disable_blank();
        set_obs(2, 324, 240);
        obs_enable = 4'b1011;
        flush();
        scan();
        close_frame("disabled_channel", 4'b0000, 1'b0);
        obs_enable = 4'b1111;
        for (int x = 318; x <= 326; x++) pix(x, 240, 1'b0, 1'b0);
        flush();
        close_frame("blanking_overlap", 4'b0000, 1'b0);
        set_obs(2, 200, 400);
        flush();
    endtask

    task automatic test_boundary();
        pix(323, 243, 1'b1, 1'b0);
        pix(324, 240, 1'b1, 1'b0);
        pix(50, 100, 1'b1, 1'b0);
        pix(51, 100, 1'b1, 1'b0);
        pix(590, 100, 1'b1, 1'b0);
        pix(589, 100, 1'b1, 1'b0);
        flush();
        BallX = 10'd579;
        close_frame("finish_579_flags", 4'b0000, 1'b0);
        checks++;
        if (finish_line_reached !== 1'b0) begin
            errors++;
            $display("FAIL finish_579: got %b want 0", finish_line_reached);
        end
        BallX = 10'd580;
        pix(0, 0, 1'b0, 1'b0);
        checks++;
        if (finish_line_reached !== 1'b0) begin
            errors++;
            $display("FAIL finish_hold: got %b want 0 before close", finish_line_reached);
        end
        close_frame("finish_580_flags", 4'b0000, 1'b0);
        checks++;
        if (finish_line_reached !== 1'b1) begin
            errors++;
            $display("FAIL finish_580: got %b want 1", finish_line_reached);
        end
        BallX = 10'd320;
        close_frame("finish_clear_flags", 4'b0000, 1'b0);
        checks++;
        if (finish_line_reached !== 1'b0) begin
            errors++;
            $display("FAIL finish_clear: got %b want 0", finish_line_reached);
        end
    endtask

    task automatic test_same_cycle_close();
        set_obs(2, 324, 240);
        pix(322, 240, 1'b1, 1'b0);
        pix(0, 0, 1'b0, 1'b0);
        close_frame("same_cycle_hit", 4'b0100, 1'b1);
        close_frame("back_to_back_close", 4'b0000, 1'b0);
        set_obs(2, 200, 400);
        flush();
    endtask

    task automatic test_reset_midframe();
        set_obs(1, 324, 240);
        pix(322, 240, 1'b1, 1'b0);
        flush();
        #2;
        Reset_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(posedge Clk);
        #1;
        sb.delete();
        Reset_n = 1'b1;
        set_obs(1, 150, 400);
        flush();
        close_frame("post_reset_close", 4'b0000, 1'b0);
    endtask

    initial begin
        test_reset();
        test_priority();
        test_collision();
        test_disable_blank();
        test_boundary();
        test_same_cycle_close();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
